// File: rtl/ysyx_22040088_lsu_pkg.sv
// rtl/ysyx_22040088_lsu_pkg.sv - LSU FSM states, access-size codes and size helpers
package ysyx_22040088_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Size codes reuse the one-hot mem_mask encoding from decode.
    typedef enum logic [3:0] {
        SZ_DWORD = 4'b0001,
        SZ_WORD  = 4'b0010,
        SZ_HALF  = 4'b0100,
        SZ_BYTE  = 4'b1000
    } size_t;

    function automatic size_t mask_to_size(input logic [3:0] mask);
        if (mask[0])      return SZ_DWORD;
        else if (mask[1]) return SZ_WORD;
        else if (mask[2]) return SZ_HALF;
        else              return SZ_BYTE;
    endfunction

    // Low address bits that must be zero for a naturally aligned access (size-1).
    function automatic logic [2:0] align_bits(input size_t size);
        case (size)
            SZ_DWORD: return 3'b111;
            SZ_WORD:  return 3'b011;
            SZ_HALF:  return 3'b001;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_if.sv
// rtl/ysyx_22040088_lsu_if.sv - valid/ready request/response data bus between LSU and memory
interface ysyx_22040088_lsu_if #(
    parameter int ADDR_W = 64
);
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [ADDR_W-1:0] bus_req_addr;
    logic              bus_req_wen;
    logic [63:0]       bus_req_wdata;
    logic [7:0]        bus_req_wstrb;
    logic              bus_resp_valid;
    logic [63:0]       bus_resp_rdata;

    modport master (
        output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata
    );
endinterface

// File: rtl/ysyx_22040088_lsu_align.sv
// rtl/ysyx_22040088_lsu_align.sv - byte-lane alignment of store data/strobes and load extraction/extension
module ysyx_22040088_lsu_align
    import ysyx_22040088_lsu_pkg::*;
(
    input  size_t       size,
    input  logic [2:0]  off,
    input  logic        ld_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] resp_rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);
    logic [5:0]  bit_off;
    logic [7:0]  strb_base;
    logic [63:0] raw;

    assign bit_off  = {off, 3'b000};
    assign raw      = resp_rdata >> bit_off;
    assign wdata_sh = wdata << bit_off;
    assign wstrb    = strb_base << off;

    always_comb begin
        strb_base = 8'h00;
        rdata_ext = raw;
        case (size)
            SZ_DWORD: begin
                strb_base = 8'hFF;
                rdata_ext = raw;
            end
            SZ_WORD: begin
                strb_base = 8'h0F;
                rdata_ext = ld_unsigned ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            end
            SZ_HALF: begin
                strb_base = 8'h03;
                rdata_ext = ld_unsigned ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            end
            SZ_BYTE: begin
                strb_base = 8'h01;
                rdata_ext = ld_unsigned ? {56'b0, raw[7:0]} : {{56{raw[7]}}, raw[7:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ysyx_22040088_lsu.sv
// rtl/ysyx_22040088_lsu.sv - load/store sequencer, one bus transaction per access; option YSYX_22040088_LSU_MISALIGN_CHECK_EN
module ysyx_22040088_lsu
    import ysyx_22040088_lsu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ena,
    input  logic              mem_wen,
    input  logic [3:0]        mem_mask,
    input  logic              ld_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [63:0]       rdata,
    output logic              misalign,
    ysyx_22040088_lsu_if.master bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       resp_q;
    size_t             size_q;
    logic              wen_q;
    logic              uns_q;
    logic              accept;
    size_t             size_in;
    logic              mis_in;
    logic [2:0]        off_eff;
    logic [7:0]        strb;
    logic [63:0]       wdata_sh;
    logic [63:0]       rdata_ext;

    assign accept  = mem_ena && (mem_mask != 4'b0000);
    assign size_in = mask_to_size(mem_mask);
    // Aligned accesses are unaffected by the truncation; misaligned ones either never reach the bus or get rounded down.
    assign off_eff = addr_q[2:0] & ~align_bits(size_q);

`ifdef YSYX_22040088_LSU_MISALIGN_CHECK_EN
    logic mis_q;
    assign mis_in   = |(addr[2:0] & align_bits(size_in));
    assign misalign = (state_q == ST_DONE) && mis_q;

    always_ff @(posedge clk) begin
        if (rst)                               mis_q <= 1'b0;
        else if (state_q == ST_IDLE && accept) mis_q <= mis_in;
    end
`else
    assign mis_in   = 1'b0;
    assign misalign = 1'b0;
`endif

    ysyx_22040088_lsu_align u_align (
        .size        (size_q),
        .off         (off_eff),
        .ld_unsigned (uns_q),
        .wdata       (wdata_q),
        .resp_rdata  (resp_q),
        .wstrb       (strb),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    assign bus.bus_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign bus.bus_req_wen   = wen_q;
    assign bus.bus_req_wdata = wdata_sh;
    assign bus.bus_req_wstrb = wen_q ? strb : 8'h00;
    assign done              = (state_q == ST_DONE);
    assign rdata             = (done && !wen_q && !misalign) ? rdata_ext : 64'd0;

    always_comb begin
        state_d           = state_q;
        stall             = 1'b0;
        bus.bus_req_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = mis_in ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall             = 1'b1;
                bus.bus_req_valid = 1'b1;
                if (bus.bus_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus.bus_resp_valid) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= 64'd0;
            resp_q  <= 64'd0;
            size_q  <= SZ_DWORD;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= size_in;
                wen_q   <= mem_wen;
                uns_q   <= ld_unsigned;
            end
            if (state_q == ST_WAIT && bus.bus_resp_valid) resp_q <= bus.bus_resp_rdata;
        end
    end
endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// tb/tb_ysyx_22040088_lsu.sv - table-driven scoreboard bench for the LSU sequencer
module tb_ysyx_22040088_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ena, mem_wen, ld_unsigned;
    logic [3:0]  mem_mask;
    logic [63:0] addr, wdata, rdata;
    logic        stall, done, misalign;

    ysyx_22040088_lsu_if #(.ADDR_W(64)) bus ();

    ysyx_22040088_lsu #(.ADDR_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ena     (mem_ena),
        .mem_wen     (mem_wen),
        .mem_mask    (mem_mask),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .done        (done),
        .rdata       (rdata),
        .misalign    (misalign),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [3:0]  mask;
        logic        uns;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] resp;
        logic [63:0] e_addr;
        logic [7:0]  e_wstrb;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [3:0] mask, input logic uns,
                                input logic [63:0] a, input logic [63:0] wd, input logic [63:0] resp,
                                input logic [63:0] e_addr, input logic [7:0] e_wstrb,
                                input logic [63:0] e_wdata, input logic [63:0] e_rdata);
        vec_t v;
        v.wen = wen; v.mask = mask; v.uns = uns; v.a = a; v.wd = wd; v.resp = resp;
        v.e_addr = e_addr; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after DONE (idle again).
    task automatic do_access(input vec_t v, input int rdy_dly, input int rsp_dly);
        int          done_cnt;
        logic [63:0] e;
        done_cnt    = 0;
        mem_ena     = 1'b1;
        mem_wen     = v.wen;
        mem_mask    = v.mask;
        ld_unsigned = v.uns;
        addr        = v.a;
        wdata       = v.wd;
        sb_q.push_back(v.e_rdata);
        #1 chk("stall_accept", stall, 1);
        @(negedge clk);
        mem_ena = 1'b0;
        mem_wen = ~v.wen;
        addr    = ~v.a;
        wdata   = ~v.wd;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("req_valid", bus.bus_req_valid, 1);
            chk("req_addr", bus.bus_req_addr, v.e_addr);
            chk("req_wen", bus.bus_req_wen, v.wen);
            chk("req_wstrb", bus.bus_req_wstrb, v.e_wstrb);
            chk("req_wdata", bus.bus_req_wdata, v.e_wdata);
            chk("stall_req", stall, 1);
            bus.bus_req_ready = (i == rdy_dly);
            @(negedge clk);
        end
        bus.bus_req_ready = 1'b0;
        for (int i = 0; i <= rsp_dly; i++) begin
            chk("stall_wait", stall, 1);
            chk("req_valid_wait", bus.bus_req_valid, 0);
            if (done) done_cnt++;
            if (i == rsp_dly) begin
                bus.bus_resp_valid = 1'b1;
                bus.bus_resp_rdata = v.resp;
            end
            @(negedge clk);
        end
        bus.bus_resp_valid = 1'b0;
        bus.bus_resp_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        if (done) done_cnt++;
        chk("done", done, 1);
        chk("stall_done", stall, 0);
        chk("misalign", misalign, 0);
        e = sb_q.pop_front();
        chk("rdata", rdata, e);
        @(negedge clk);
        if (done) done_cnt++;
        chk("done_once", done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_ena = 1'b0; mem_wen = 1'b0; mem_mask = 4'b0; ld_unsigned = 1'b0;
        addr = 64'd0; wdata = 64'd0;
        bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0; bus.bus_resp_rdata = 64'd0;

        vecs.push_back(mk(0, 4'b0001, 0, 64'h80000008, 0, 64'h0123456789ABCDEF, 64'h80000008, 8'h00, 0, 64'h0123456789ABCDEF));
        vecs.push_back(mk(0, 4'b1000, 0, 64'h80000003, 0, 64'h0000000080000000, 64'h80000000, 8'h00, 0, 64'hFFFFFFFFFFFFFF80));
        vecs.push_back(mk(0, 4'b1000, 1, 64'h80000003, 0, 64'h0000000080000000, 64'h80000000, 8'h00, 0, 64'h0000000000000080));
        vecs.push_back(mk(0, 4'b0100, 0, 64'h80000004, 0, 64'h0000F00D00000000, 64'h80000000, 8'h00, 0, 64'hFFFFFFFFFFFFF00D));
        vecs.push_back(mk(0, 4'b0100, 1, 64'h80000004, 0, 64'h0000F00D00000000, 64'h80000000, 8'h00, 0, 64'h000000000000F00D));
        vecs.push_back(mk(0, 4'b0010, 0, 64'h80000004, 0, 64'h8000000000000000, 64'h80000000, 8'h00, 0, 64'hFFFFFFFF80000000));
        vecs.push_back(mk(0, 4'b0010, 1, 64'h80000004, 0, 64'h8000000000000000, 64'h80000000, 8'h00, 0, 64'h0000000080000000));
        vecs.push_back(mk(1, 4'b0100, 0, 64'h80000006, 64'h1234, 64'hDEAD, 64'h80000000, 8'hC0, 64'h1234000000000000, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 64'h80000004, 64'hAABBCCDD, 0, 64'h80000000, 8'hF0, 64'hAABBCCDD00000000, 0));
        vecs.push_back(mk(1, 4'b0001, 0, 64'h80000010, 64'h1122334455667788, 0, 64'h80000010, 8'hFF, 64'h1122334455667788, 0));
        vecs.push_back(mk(1, 4'b1000, 0, 64'h80000007, 64'hFFA5, 0, 64'h80000000, 8'h80, 64'hA500000000000000, 0));
        vecs.push_back(mk(0, 4'b1010, 1, 64'h80000000, 0, 64'h12345678FFFFFFFF, 64'h80000000, 8'h00, 0, 64'h00000000FFFFFFFF));
        vecs.push_back(mk(0, 4'b0111, 0, 64'h80000018, 0, 64'hFEDCBA9876543210, 64'h80000018, 8'h00, 0, 64'hFEDCBA9876543210));

        repeat (2) @(negedge clk);
        chk("rst_valid", bus.bus_req_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_wen", bus.bus_req_wen, 0);
        chk("rst_wstrb", bus.bus_req_wstrb, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", bus.bus_req_addr, 0);
        chk("rst_wdata", bus.bus_req_wdata, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back accesses with a mix of bus delays.
        foreach (vecs[i]) do_access(vecs[i], (i == 0) ? 0 : i % 3, (i == 0) ? 0 : i % 2);

        // sh held under 4 cycles of back-pressure, then sw with a 5-cycle late acknowledge.
        do_access(vecs[7], 4, 0);
        do_access(vecs[8], 0, 5);

        // mem_mask == 0 is ignored.
        mem_ena = 1'b1; mem_mask = 4'b0000; addr = 64'h80000000;
        #1 chk("mask0_stall", stall, 0);
        @(negedge clk);
        mem_ena = 1'b0;
        chk("mask0_valid", bus.bus_req_valid, 0);
        chk("mask0_done", done, 0);

        // Unsolicited response in IDLE.
        bus.bus_resp_valid = 1'b1;
        @(negedge clk);
        bus.bus_resp_valid = 1'b0;
        chk("unsol_done", done, 0);
        chk("unsol_valid", bus.bus_req_valid, 0);

        // Reset while waiting for the response; the late response must be dropped.
        mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b1000; ld_unsigned = 1'b0; addr = 64'h80000003;
        @(negedge clk);
        mem_ena = 1'b0;
        bus.bus_req_ready = 1'b1;
        @(negedge clk);
        bus.bus_req_ready = 1'b0;
        chk("rstw_stall_wait", stall, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_stall", stall, 0);
        chk("rstw_valid", bus.bus_req_valid, 0);
        chk("rstw_addr", bus.bus_req_addr, 0);
        bus.bus_resp_valid = 1'b1; bus.bus_resp_rdata = 64'hFF;
        @(negedge clk);
        bus.bus_resp_valid = 1'b0;
        chk("rstw_late_done", done, 0);
        @(negedge clk);
        chk("rstw_late_done2", done, 0);

`ifdef YSYX_22040088_LSU_MISALIGN_CHECK_EN
        mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0010; ld_unsigned = 1'b0; addr = 64'h80000002;
        #1 chk("mis_stall_accept", stall, 1);
        @(negedge clk);
        mem_ena = 1'b0;
        chk("mis_done", done, 1);
        chk("mis_flag", misalign, 1);
        chk("mis_valid", bus.bus_req_valid, 0);
        chk("mis_rdata", rdata, 0);
        chk("mis_stall", stall, 0);
        @(negedge clk);
        chk("mis_done_after", done, 0);
        chk("mis_valid_after", bus.bus_req_valid, 0);
`else
        do_access(mk(0, 4'b0010, 0, 64'h80000002, 0, 64'hCAFEBABE87654321, 64'h80000000, 8'h00, 0, 64'hFFFFFFFF87654321), 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_22040088_lsu.md
# ysyx_22040088_lsu

Multi-cycle load/store sequencer between the decode control signals (`mem_ena`, `mem_wen`, `mem_mask`, unsigned-load select) and a 64-bit valid/ready data bus. It turns one decoded memory instruction into exactly one bus transaction and stalls the core until the response returns. It aligns store data and byte strobes, then extracts and sign- or zero-extends load data. NPC integrates it in the EX/MEM stage, and its `stall` output gates PC and register-file update.

## Interface
- `ADDR_W`, 64: address width.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mem_ena` input 1: instruction accesses memory.
- `mem_wen` input 1: 1 for store, 0 for load.
- `mem_mask` input 4: one-hot access size. `0001` is doubleword, `0010` word, `0100` half, `1000` byte.
- `ld_unsigned` input 1: zero-extend the load result (lwu/lhu/lbu).
- `addr` input ADDR_W: effective address from the ALU.
- `wdata` input 64: store data, right-justified.
- `stall` output 1: hold the pipeline.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 64: extended load result, valid while `done`.
- `misalign` output 1: misaligned access, valid while `done`.
- `bus_req_valid` output 1: request valid.
- `bus_req_ready` input 1: request accepted.
- `bus_req_addr` output ADDR_W: address with `[2:0]` forced to 0.
- `bus_req_wen` output 1: write request.
- `bus_req_wdata` output 64: store data shifted into byte lanes.
- `bus_req_wstrb` output 8: byte strobes, all 0 for loads.
- `bus_resp_valid` input 1: response or write acknowledge.
- `bus_resp_rdata` input 64: raw doubleword read data.

## Operation
- FSM states:
  - IDLE:
    - Accepts an access when `mem_ena` and `mem_mask != 0`. It latches `addr`, `wdata`, size, `mem_wen` and `ld_unsigned`, then moves to REQ.
    - If `mem_mask == 0`, the access is ignored: no stall, no transaction.
  - REQ:
    - `bus_req_valid=1`, and the request outputs are held stable.
    - `bus_req_ready=1` moves the FSM to WAIT.
  - WAIT: `bus_resp_valid=1` captures `bus_resp_rdata` and moves the FSM to DONE.
  - DONE: `done=1`, then unconditionally back to IDLE.
- A non-one-hot `mem_mask` resolves by priority: `0001` > `0010` > `0100` > `1000`.
- Size in bytes is 8, 4, 2 or 1. `off = addr[2:0]`.
- Strobes: `wstrb = ((1<<size)-1) << off`, truncated to 8 bits.
- Store data: `bus_req_wdata = wdata << (off*8)`.
- Load data: `raw = bus_resp_rdata >> (off*8)`. The low `size*8` bits are kept and extended to 64 bits by sign, or by zero when `ld_unsigned`. Doubleword loads pass through unchanged.
- Stores also wait for `bus_resp_valid` (write acknowledge). `rdata` is 0 for stores.
- `stall = (state==IDLE && accept) || state==REQ || state==WAIT`. It is combinational and low in DONE.
- An unsolicited `bus_resp_valid` in IDLE, REQ or DONE is ignored.

## Timing
- Reset values: state IDLE; `bus_req_valid`, `done`, `misalign`, `bus_req_wen`, `bus_req_wstrb` all 0; `rdata`, `bus_req_addr`, `bus_req_wdata` all 0.
- `rst` mid-transaction forces IDLE on the next edge and drops `bus_req_valid`. A later response to the aborted request is ignored.
- Minimum latency is 3 cycles from the accept edge to `done`. This assumes `bus_req_ready` in the first REQ cycle and `bus_resp_valid` in the first WAIT cycle.
- `stall` is high during the accept cycle and during REQ and WAIT. It is low in the DONE cycle, when the core retires the instruction.
- Back-to-back accesses: the next access is accepted in the cycle after DONE. There is no pipelining of requests.

## Configuration
- With `YSYX_22040088_LSU_MISALIGN_CHECK_EN` defined:
  - In IDLE, an access with `off % size != 0` skips REQ and WAIT and goes directly to DONE with `misalign=1` and `rdata=0`.
  - No bus request is issued.
  - `stall` is high for the accept cycle only.
- Without the macro:
  - `misalign` is tied to 0.
  - `off` is truncated to natural alignment (`off & ~(size-1)`), and the access proceeds normally.

## Structure
- A shared package `ysyx_22040088_lsu_pkg` holds the FSM state encodings (IDLE/REQ/WAIT/DONE) and the size codes matching the `mem_mask` one-hot values.
- Sub-module `ysyx_22040088_lsu_align` is purely combinational. It computes wstrb, shifted wdata, and the extracted and extended rdata from size, `off` and `ld_unsigned`. The top level keeps the FSM and the latches.

## Test plan
- ld, `addr=0x80000008`, ready and resp immediate:
  - `bus_req_addr=0x80000008`, `wstrb=0`.
  - `done` arrives 3 cycles after accept.
  - `rdata` equals `bus_resp_rdata`.
- lb, `addr=0x80000003`, `bus_resp_rdata=0x00000000_80000000`: `rdata=0xFFFFFFFFFFFFFF80`. With `ld_unsigned` (lbu), `rdata=0x80`.
- sh, `addr=0x80000006`, `wdata=0x1234`:
  - `wstrb=0xC0`, `bus_req_wdata=0x1234_0000_0000_0000`.
  - `bus_req_valid` is held for 4 cycles of `bus_req_ready=0`.
- sw with `bus_resp_valid` delayed 5 cycles: `stall` stays high throughout and `done` is asserted once.
- `rst` asserted in WAIT: IDLE next cycle, `stall=0`, and a late `bus_resp_valid` causes no `done`.
- lw, `addr=0x80000002`:
  - Macro on: `done` and `misalign=1` one cycle after accept, and no `bus_req_valid`.
  - Macro off: `bus_req_addr=0x80000000`, `wstrb=0` (load), and low-word data is returned.
